alu_arbiter: RTL

- Shares the single combinational `alu` between two requesters: 0 = execute stage, 1 = address/branch unit.
- Each request is accepted through a valid/ready handshake. The arbiter registers the operands, drives them into the ALU for one cycle, and captures out/flags. It then returns the result to the winning requester with a one-cycle resp_valid pulse.
- When both requesters are valid, access is granted round-robin.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute
// stage (requester 0) and the address/branch unit (requester 1).
//
// state | meaning
// IDLE  | waiting for a request; combinational ready to the winner
// EXEC  | latched operands drive the ALU; result captured at cycle end
// DONE  | one-cycle response pulse to the granted requester
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int FLAGW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_out,
    output logic [FLAGW-1:0] resp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [FLAGW-1:0] alu_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] resp_out_q, resp_out_d;
    logic [FLAGW-1:0] resp_flags_q, resp_flags_d;

    logic pick0, pick1;

    // On a tie the requester that did not win last time goes first.
    assign pick0 = req0_valid && (!req1_valid || last_grant_q);
    assign pick1 = req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        resp_out_d   = resp_out_q;
        resp_flags_d = resp_flags_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick0) begin
                    req0_ready   = 1'b1;
                    grant_d      = 1'b0;
                    last_grant_d = 1'b0;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    op_d         = req0_op;
                    state_d      = EXEC;
                end else if (pick1) begin
                    req1_ready   = 1'b1;
                    grant_d      = 1'b1;
                    last_grant_d = 1'b1;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    op_d         = req1_op;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_out_d   = alu_out;
                resp_flags_d = alu_flags;
                state_d      = DONE;
            end
            DONE: begin
                resp0_valid = !grant_q;
                resp1_valid = grant_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign resp_out   = resp_out_q;
    assign resp_flags = resp_flags_q;
    assign busy       = (state_q != IDLE);

endmodule
